// File: rtl/debounce_bank_pkg.sv
// Shared state encoding and default parameters for the switch debounce bank.
package debounce_bank_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT0 = 2'b01,
        ONE   = 2'b10,
        WAIT1 = 2'b11
    } db_state_t;

    localparam int DEF_CH        = 4;
    localparam int DEF_N         = 19;
    localparam int DEF_SYNC      = 2;
    localparam int DEF_REPEAT_EN = 0;
    localparam int DEF_RD        = 23;
    localparam int DEF_RR        = 21;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: ZERO/WAIT1/ONE/WAIT0 FSM with down-counter and optional auto-repeat.
//
// state | meaning
// ZERO  | debounced low, input agrees
// WAIT1 | debounced low, input high, counting toward rise
// ONE   | debounced high, input agrees (repeat counter runs)
// WAIT0 | debounced high, input low, counting toward fall (repeat frozen)
module debounce_ch
    import debounce_bank_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int REPEAT_EN = DEF_REPEAT_EN,
    parameter int RD        = DEF_RD,
    parameter int RR        = DEF_RR
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_s,
    output logic level,
    output logic rise_tick,
    output logic fall_tick,
    output logic rpt_tick
);

    localparam logic [N-1:0] CNT_LOAD = '1;
    localparam logic [N-1:0] CNT_ONE  = N'(1);

    db_state_t    state;
    logic [N-1:0] cnt;
    logic         rise_now;
    logic         fall_now;

    // Terminal count: the last sample of the interval is being consumed this cycle.
    assign rise_now = (state == WAIT1) && sw_s  && (cnt <= CNT_ONE);
    assign fall_now = (state == WAIT0) && !sw_s && (cnt <= CNT_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ZERO;
            cnt       <= '0;
            level     <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            case (state)
                ZERO: begin
                    if (sw_s) begin
                        state <= WAIT1;
                        cnt   <= CNT_LOAD;
                    end
                end
                WAIT1: begin
                    if (!sw_s) begin
                        state <= ZERO;
                    end else if (rise_now) begin
                        state     <= ONE;
                        level     <= 1'b1;
                        rise_tick <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state <= WAIT0;
                        cnt   <= CNT_LOAD;
                    end
                end
                WAIT0: begin
                    if (sw_s) begin
                        state <= ONE;
                    end else if (fall_now) begin
                        state     <= ZERO;
                        level     <= 1'b0;
                        fall_tick <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= ZERO;
                    level <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rpt
            localparam logic [RD-1:0] FIRST_LOAD  = '1;
            localparam logic [RD-1:0] PERIOD_LOAD = RD'((64'd1 << RR) - 64'd1);
            localparam logic [RD-1:0] R_ONE       = RD'(1);

            logic [RD-1:0] rcnt;

            // Ticks only leave ONE, so they can never share a cycle with rise/fall ticks.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rcnt     <= '0;
                    rpt_tick <= 1'b0;
                end else begin
                    rpt_tick <= 1'b0;
                    if (rise_now) begin
                        rcnt <= FIRST_LOAD;
                    end else if (state == ONE) begin
                        if (rcnt == '0) begin
                            rpt_tick <= 1'b1;
                            rcnt     <= PERIOD_LOAD;
                        end else begin
                            rcnt <= rcnt - R_ONE;
                        end
                    end else if (state == WAIT0 && !fall_now) begin
                        rcnt <= rcnt;
                    end else begin
                        rcnt <= '0;
                    end
                end
            end
        end else begin : g_no_rpt
            assign rpt_tick = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Bank of CH independent switch debouncers with per-channel synchronizers.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int CH        = DEF_CH,
    parameter int N         = DEF_N,
    parameter int SYNC      = DEF_SYNC,
    parameter int REPEAT_EN = DEF_REPEAT_EN,
    parameter int RD        = DEF_RD,
    parameter int RR        = DEF_RR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick,
    output logic [CH-1:0] rpt_tick,
    output logic          any_level
);

    logic [CH-1:0] sync_q [SYNC];
    logic [CH-1:0] sw_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sw;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sw_s = sync_q[SYNC-1];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_ch #(
            .N         (N),
            .REPEAT_EN (REPEAT_EN),
            .RD        (RD),
            .RR        (RR)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sw_s      (sw_s[i]),
            .level     (db_level[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
            .rpt_tick  (rpt_tick[i])
        );
    end

    // OR of registered levels; no extra flop so it tracks db_level in the same cycle.
    assign any_level = |db_level;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CH, default 4: number of independent switch channels (1..32).
REQ-002 Parameter N, default 19: debounce counter bits; debounce interval D = 2^N clk cycles.
REQ-003 Parameter SYNC, default 2: synchronizer flip-flop stages per channel (2..4).
REQ-004 Parameter REPEAT_EN, default 0: 1 enables auto-repeat ticks.
REQ-005 Parameter RD, default 23: first-repeat delay = 2^RD cycles after rise.
REQ-006 Parameter RR, default 21: repeat period = 2^RR cycles (RR <= RD).
REQ-007 clk  input  1  single system clock, all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 sw  input  CH  raw asynchronous switch inputs, bit i = channel i.
REQ-010 db_level  output  CH  debounced level per channel, registered.
REQ-011 rise_tick  output  CH  one-cycle pulse on debounced 0->1.
REQ-012 fall_tick  output  CH  one-cycle pulse on debounced 1->0.
REQ-013 rpt_tick  output  CH  one-cycle auto-repeat pulse while held.
REQ-014 any_level  output  1  OR of all db_level bits.

Function
REQ-015 Each sw bit SHALL pass through SYNC flip-flops; sw_s denotes the final stage.
REQ-016 Each channel SHALL run an independent FSM: ZERO, WAIT1, ONE, WAIT0.
REQ-017 ZERO: sw_s=1 -> WAIT1, counter loaded 2^N-1; else stay.
REQ-018 WAIT1: sw_s=1 decrements counter; sw_s=0 -> ZERO, no tick, counter discarded.
REQ-019 If sw_s=1 on every cycle t0..t0+D-1 (t0 = first high cycle in ZERO), db_level SHALL rise at cycle t0+D with rise_tick high that same cycle only.
REQ-020 ONE/WAIT0 SHALL mirror ZERO/WAIT1 for sw_s=0; db_level falls at t0+D with fall_tick that cycle; sw_s=1 in WAIT0 -> ONE, no tick.
REQ-021 db_level SHALL be 0 in ZERO/WAIT1 and 1 in ONE/WAIT0; all outputs registered.
REQ-022 Counter decrement SHALL be N-bit, never wrap below 0; transition taken on reaching 0.
REQ-023 REPEAT_EN=1: in ONE a repeat counter SHALL emit rpt_tick 2^RD cycles after rise_tick, then every 2^RR cycles while in ONE.
REQ-024 Repeat counter SHALL freeze in WAIT0, resume on return to ONE, clear on entry to ZERO.
REQ-025 rpt_tick SHALL never coincide with rise_tick or fall_tick on the same channel.
REQ-026 REPEAT_EN=0: rpt_tick SHALL be constant 0 and repeat logic SHALL be omitted.
REQ-027 Channels SHALL not interact; simultaneous events on several channels each produce their own ticks in the same cycle.
REQ-028 Illegal state encoding SHALL return to ZERO next cycle.

Reset
REQ-029 reset SHALL clear synchronizers, counters, repeat counters, all FSMs to ZERO, all outputs to 0 on next clk edge.
REQ-030 reset during ONE/WAIT0 SHALL drop db_level to 0 without fall_tick.
REQ-031 After reset deassert, a held-high input SHALL produce a normal rise after SYNC+D cycles.

Structure
REQ-032 Shared package SHALL hold the 2-bit state encoding (ZERO=00, WAIT0=01, ONE=10, WAIT1=11) and default parameter constants.
REQ-033 Per-channel logic SHALL be sub-module debounce_ch (parameters N, REPEAT_EN, RD, RR), generated CH times; synchronizer and any_level in top.

Verification (CH=4, N=3 so D=8, SYNC=2, REPEAT_EN=1, RD=5, RR=3)
REQ-034 sw[0] 0->1 held -> db_level[0] high 10 cycles after the first clk edge sampling sw high (2 sync + 8), rise_tick[0] one cycle, any_level=1.
REQ-035 sw[1] high 5 cycles then low -> no rise_tick[1], db_level[1] stays 0; later 8-cycle hold debounces normally.
REQ-036 sw[2] held 60 cycles after rise -> rpt_tick[2] at rise+32, +40, +48, +56; none with rise_tick.
REQ-037 sw[3] released from ONE, 3-cycle high glitch during WAIT0 -> no fall_tick; stable low 8 cycles -> fall_tick[3], db_level[3]=0.
REQ-038 sw=4'b1111 simultaneously -> all four rise_tick bits in same cycle.
REQ-039 reset asserted with db_level=4'b1111 -> all outputs 0 next cycle, no fall_tick; rise after 10 cycles post-deassert.
